// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle ops, WIDTH-cycle shift-add MUL; start ignored while busy_o, done_o pulses per result.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle combinational multiply (busy_o tied low).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1101;
  localparam logic [3:0] OP_SLLV = 4'b1100;
  localparam logic [3:0] OP_LUI  = 4'b1111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] w_alu_res;

  always_comb begin
    w_alu_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  w_alu_res = src1_i + src2_i;
      OP_SUB:  w_alu_res = src1_i - src2_i;
      OP_AND:  w_alu_res = src1_i & src2_i;
      OP_OR:   w_alu_res = src1_i | src2_i;
      OP_SLT:  w_alu_res = ($signed(src1_i) < $signed(src2_i)) ? ONE : '0;
      OP_SLTU: w_alu_res = (src1_i < src2_i) ? ONE : '0;
      OP_SLL:  w_alu_res = src2_i << shamt_i;
      OP_SLLV: w_alu_res = src2_i << src1_i[4:0];
      OP_LUI:  w_alu_res = WIDTH'({src2_i[15:0], 16'h0000});
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL:  w_alu_res = src1_i * src2_i;
`endif
      default: w_alu_res = '0;
    endcase
  end

  assign done_o = (r_state == S_DONE);

`ifdef ALU_SEQ_FAST_MUL_EN

  assign busy_o = 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else if (start_i) begin
      result_o <= w_alu_res;
      zero_o   <= (w_alu_res == '0);
      r_state  <= S_DONE;
    end else begin
      r_state  <= S_IDLE;
    end
  end

`else

  localparam logic [1:0] S_MUL = 2'd1;
  localparam int         CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_acc_next;

  // Last iteration's partial product must land in result_o on the same edge.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign busy_o     = (r_state == S_MUL);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i && ALUCtrl_i == OP_MUL) begin
            r_mcand  <= src1_i;
            r_mplier <= src2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end else if (start_i) begin
            result_o <= w_alu_res;
            zero_o   <= (w_alu_res == '0);
            r_state  <= S_DONE;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            result_o <= w_acc_next;
            zero_o   <= (w_acc_next == '0);
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule
